// File: rtl/plot_sink.sv
// plot_sink: receiving end of the pixel-plot stream.
//   Clips x/y/colour/plot requests to the visible screen, converts them to a
//   linear framebuffer address (y*WIDTH + x), queues them in a small FIFO and
//   drains the FIFO to the framebuffer write port with a ready/valid handshake.
//   A single-cycle clear request starts a full-screen fill sweep.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   xin, yin, colourin   pixel coordinates and colour from the drawer
//   plot                 one pixel per high cycle
//   clear, clear_colour  clear-screen request and its fill colour
//   mem_ready            framebuffer accepts the presented write this cycle
//   mem_addr, mem_data   presented framebuffer address / colour
//   mem_we               write valid
//   busy, full           FIFO/engine activity and FIFO-full flags
//   overflow             sticky: an in-bounds plot was dropped
module plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [11:0]       xin,
  input  logic [10:0]       yin,
  input  logic [2:0]        colourin,
  input  logic              plot,
  input  logic              clear,
  input  logic [2:0]        clear_colour,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              full,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   fifo_q [DEPTH];
  logic [ENT_W-1:0]   fifo_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d, count_rem_s;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [2:0]         mem_data_q, mem_data_d;
  logic               mem_we_q, mem_we_d;
  logic               busy_q, busy_d, full_q, full_d, overflow_q, overflow_d;
  logic               clr_pend_q, clr_pend_d;
  logic [2:0]         clr_colour_q, clr_colour_d;

  logic               in_bounds_s, done_s, pop_s, push_s, drop_s, flush_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [ENT_W-1:0]   entry_s, head_s;
  logic [2:0]         new_colour_s;

  // Clip test and full-precision address conversion of the incoming pixel.
  always_comb begin
    in_bounds_s = (32'(xin) < 32'(WIDTH)) && (32'(yin) < 32'(HEIGHT));
    addr_s      = ADDR_W'(32'(yin) * 32'(WIDTH) + 32'(xin));
    entry_s     = {addr_s, colourin};
  end

  // FIFO bookkeeping and the write/clear state machine.
  always_comb begin
    done_s  = mem_we_q && mem_ready;
    pop_s   = (state_q == ST_WRITE) && done_s;
    // A clear accepted from IDLE, or from WRITE at a completing transfer,
    // empties the queue (including any plot sampled on the same edge).
    flush_s = ((state_q == ST_IDLE) && clear) ||
              ((state_q == ST_WRITE) && done_s && (clear || clr_pend_q));
    push_s  = plot && in_bounds_s && !flush_s &&
              ((count_q < CNT_W'(DEPTH)) || pop_s);
    drop_s  = plot && in_bounds_s && !flush_s && !push_s;
    // A fresh clear overrides the colour of one already waiting.
    new_colour_s = clear ? clear_colour : clr_colour_q;

    fifo_d = fifo_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = entry_s;
    end else begin
      fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];
    end
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop_s);
    wr_ptr_d    = wr_ptr_q + PTR_W'(push_s);
    count_rem_s = count_q - CNT_W'(pop_s);
    count_d     = count_rem_s + CNT_W'(push_s);
    // Entry to present next: a plot pushed into an otherwise empty queue
    // bypasses the storage read.
    head_s = (count_rem_s == '0) ? entry_s : fifo_q[rd_ptr_d];
    if (flush_s) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      count_d  = count_d;
    end

    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = mem_we_q;
    clr_pend_d   = clr_pend_q;
    clr_colour_d = clr_colour_q;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d      = ST_CLEAR;
          mem_addr_d   = '0;
          mem_data_d   = clear_colour;
          mem_we_d     = 1'b1;
          clr_colour_d = clear_colour;
        end else if (count_q != '0) begin
          state_d                = ST_WRITE;
          {mem_addr_d, mem_data_d} = fifo_q[rd_ptr_q];
          mem_we_d               = 1'b1;
        end else begin
          mem_we_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (done_s) begin
          if (clear || clr_pend_q) begin
            state_d      = ST_CLEAR;
            mem_addr_d   = '0;
            mem_data_d   = new_colour_s;
            mem_we_d     = 1'b1;
            clr_pend_d   = 1'b0;
            clr_colour_d = new_colour_s;
          end else if (count_d != '0) begin
            {mem_addr_d, mem_data_d} = head_s;
            mem_we_d                 = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            mem_we_d = 1'b0;
          end
        end else if (clear) begin
          // Stalled transfer: hold it and remember the clear for later.
          clr_pend_d   = 1'b1;
          clr_colour_d = clear_colour;
        end else begin
          mem_we_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (done_s) begin
          if (clear || clr_pend_q) begin
            mem_addr_d   = '0;
            mem_data_d   = new_colour_s;
            clr_pend_d   = 1'b0;
            clr_colour_d = new_colour_s;
          end else if (mem_addr_q == LAST_ADDR) begin
            if (count_d != '0) begin
              state_d                  = ST_WRITE;
              {mem_addr_d, mem_data_d} = head_s;
            end else begin
              state_d  = ST_IDLE;
              mem_we_d = 1'b0;
            end
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end else if (clear) begin
          clr_pend_d   = 1'b1;
          clr_colour_d = clear_colour;
        end else begin
          mem_we_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        mem_we_d = 1'b0;
      end
    endcase

    busy_d     = (count_d != '0) || (state_d != ST_IDLE);
    full_d     = (count_d == CNT_W'(DEPTH));
    overflow_d = overflow_q || drop_s;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= 3'd0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      clr_pend_q   <= 1'b0;
      clr_colour_q <= 3'd0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      clr_pend_q   <= clr_pend_d;
      clr_colour_q <= clr_colour_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_plot_sink.sv
module tb_plot_sink;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] xin = 12'd0;
  logic [10:0] yin = 11'd0;
  logic [2:0]  colourin = 3'd0;
  logic        plot = 1'b0;
  logic        clear = 1'b0;
  logic [2:0]  clear_colour = 3'd0;
  logic        mem_ready = 1'b0;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we, busy, full, overflow;

  plot_sink dut (
    .clk(clk), .reset_n(reset_n), .xin(xin), .yin(yin), .colourin(colourin),
    .plot(plot), .clear(clear), .clear_colour(clear_colour), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .busy(busy),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of pending {addr, colour} writes and sticky overflow.
  logic [17:0] q[$];
  logic        ovf_m = 1'b0;
  logic        stall_prev = 1'b0;
  logic [14:0] prev_addr = 15'd0;
  logic [2:0]  prev_data = 3'd0;

  // One clock with the model: retire a completing write, queue or drop a plot,
  // then check the flags just after the edge.
  task automatic tick();
    logic comp;
    logic inb;
    logic [17:0] exp_e;
    int a;
    comp = (mem_we === 1'b1) && (mem_ready === 1'b1);
    if (stall_prev) begin
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== prev_addr || mem_data !== prev_data) begin
        n_bad++;
        $display("FAIL stall_hold: we=%0b addr=%0d data=%0d, required we=1 addr=%0d data=%0d",
                 mem_we, mem_addr, mem_data, prev_addr, prev_data);
      end
    end
    if (comp) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr=%0d data=%0d, required no write", mem_addr, mem_data);
      end else begin
        exp_e = q.pop_front();
        if ({mem_addr, mem_data} !== exp_e) begin
          n_bad++;
          $display("FAIL write_order: addr=%0d data=%0d, required addr=%0d data=%0d",
                   mem_addr, mem_data, exp_e[17:3], exp_e[2:0]);
        end
      end
    end
    inb = plot && (xin < 12'd160) && (yin < 11'd120);
    if (inb) begin
      if (q.size() < 8) begin
        a = int'(yin) * 160 + int'(xin);
        q.push_back({a[14:0], colourin});
      end else begin
        ovf_m = 1'b1;
      end
    end
    stall_prev = (mem_we === 1'b1) && (mem_ready !== 1'b1);
    prev_addr  = mem_addr;
    prev_data  = mem_data;
    @(posedge clk);
    #1;
    n_cmp++;
    if (full !== (q.size() == 8) || busy !== (q.size() != 0) || overflow !== ovf_m) begin
      n_bad++;
      $display("FAIL flags: full=%0b busy=%0b overflow=%0b, required full=%0b busy=%0b overflow=%0b",
               full, busy, overflow, q.size() == 8, q.size() != 0, ovf_m);
    end
  endtask

  task automatic plot_px(input int x, input int y, input logic [2:0] c);
    xin = 12'(x); yin = 11'(y); colourin = c; plot = 1'b1;
    tick();
    plot = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; plot = 1'b0; clear = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    q.delete();
    ovf_m = 1'b0;
    stall_prev = 1'b0;
  endtask

  task automatic drain(input string name);
    plot = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    tick();
    tick();
    n_cmp++;
    if (q.size() != 0 || mem_we !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_drain: pending=%0d we=%0b, required pending=0 we=0", name, q.size(), mem_we);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({mem_we, mem_addr, mem_data, busy, full, overflow} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_state: we=%0b addr=%0d data=%0d busy=%0b full=%0b ovf=%0b, required all 0",
               mem_we, mem_addr, mem_data, busy, full, overflow);
    end
  endtask

  task automatic test_single_plot();
    do_reset();
    mem_ready = 1'b1;
    plot_px(5, 2, 3'b101);
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_bad++; $display("FAIL single_early: we=%0b, required 0", mem_we);
    end
    tick();
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd325 || mem_data !== 3'd5) begin
      n_bad++;
      $display("FAIL single_write: we=%0b addr=%0d data=%0d, required we=1 addr=325 data=5",
               mem_we, mem_addr, mem_data);
    end
    tick();
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_bad++; $display("FAIL single_one_cycle: we=%0b, required 0", mem_we);
    end
    drain("single");
  endtask

  task automatic test_clip();
    do_reset();
    mem_ready = 1'b1;
    plot_px(160, 0, 3'd3);
    plot_px(0, 120, 3'd3);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem_we !== 1'b0 || overflow !== 1'b0) begin
        n_bad++;
        $display("FAIL clip: we=%0b overflow=%0b, required we=0 overflow=0", mem_we, overflow);
      end
      tick();
    end
  endtask

  task automatic test_overflow_stall();
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      plot_px(i * 3, i, 3'(i));
      if (i == 7) begin
        n_cmp++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          n_bad++; $display("FAIL fill8: full=%0b ovf=%0b, required full=1 ovf=0", full, overflow);
        end
      end
    end
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++; $display("FAIL overflow_set: overflow=%0b, required 1", overflow);
    end
    drain("overflow");
  endtask

  task automatic test_full_push_pop();
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) plot_px(i, 7, 3'(7 - i));
    mem_ready = 1'b1;
    plot_px(100, 100, 3'd7);
    n_cmp++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      n_bad++;
      $display("FAIL push_pop_full: overflow=%0b full=%0b, required overflow=0 full=1", overflow, full);
    end
    drain("pushpop");
  endtask

  task automatic test_random();
    logic rdy_mode;
    do_reset();
    rdy_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) rdy_mode = ($urandom_range(0, 2) != 0);
      mem_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      plot      = ($urandom_range(0, 1) == 1);
      xin       = 12'($urandom_range(0, 175));
      yin       = 11'($urandom_range(0, 130));
      colourin  = 3'($urandom_range(0, 7));
      tick();
    end
    drain("random");
  endtask

  task automatic test_clear_sweep();
    logic [17:0] e[$];
    logic [17:0] got, exp_e;
    int bad, done_cnt, first_bad_idx;
    logic plotted;
    do_reset();
    mem_ready = 1'b0;
    plot_px(10, 1, 3'd1);
    plot_px(20, 2, 3'd2);
    plot_px(30, 3, 3'd3);
    q.delete();
    e.push_back({15'd170, 3'd1});
    for (int i = 0; i < 19200; i++) e.push_back({15'(i), 3'd0});
    e.push_back({15'd487, 3'd6});
    clear_colour = 3'b000;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    clear_colour = 3'b111;
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd170 || mem_data !== 3'd1) begin
      n_bad++;
      $display("FAIL clear_pending_hold: we=%0b addr=%0d data=%0d, required we=1 addr=170 data=1",
               mem_we, mem_addr, mem_data);
    end
    bad = 0; done_cnt = 0; first_bad_idx = -1; plotted = 1'b0; got = 18'd0; exp_e = 18'd0;
    for (int cyc = 0; cyc < 60000 && e.size() != 0; cyc++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      plot = 1'b0;
      if (!plotted && done_cnt >= 100) begin
        xin = 12'd7; yin = 11'd3; colourin = 3'd6; plot = 1'b1; plotted = 1'b1;
      end
      if (mem_we === 1'b1 && mem_ready) begin
        exp_e = e.pop_front();
        if ({mem_addr, mem_data} !== exp_e) begin
          if (bad == 0) begin first_bad_idx = done_cnt; got = {mem_addr, mem_data}; end
          bad++;
        end
        done_cnt++;
      end
      @(posedge clk);
      #1;
    end
    plot = 1'b0;
    n_cmp++;
    if (bad != 0 || e.size() != 0) begin
      n_bad++;
      $display("FAIL clear_sweep: %0d wrong writes (first #%0d got addr=%0d data=%0d), %0d missing, required 0 wrong 0 missing",
               bad, first_bad_idx, got[17:3], got[2:0], e.size());
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_after: we=%0b busy=%0b ovf=%0b, required 0 0 0", mem_we, busy, overflow);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic found;
    do_reset();
    mem_ready = 1'b1;
    clear_colour = 3'b111;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd0 || mem_data !== 3'd7) begin
      n_bad++;
      $display("FAIL clear_latency: we=%0b addr=%0d data=%0d, required we=1 addr=0 data=7",
               mem_we, mem_addr, mem_data);
    end
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (mem_addr === 15'd500) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL sweep_reach_500: addr=%0d, required 500 within 1000 cycles", mem_addr);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({mem_we, mem_addr, mem_data, busy, full, overflow} !== 22'd0) begin
      n_bad++;
      $display("FAIL reset_mid_sweep: we=%0b addr=%0d data=%0d busy=%0b full=%0b ovf=%0b, required all 0",
               mem_we, mem_addr, mem_data, busy, full, overflow);
    end
    reset_n = 1'b1;
    q.delete(); ovf_m = 1'b0; stall_prev = 1'b0;
    plot_px(40, 50, 3'd2);
    tick();
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd8040 || mem_data !== 3'd2) begin
      n_bad++;
      $display("FAIL post_reset_plot: we=%0b addr=%0d data=%0d, required we=1 addr=8040 data=2",
               mem_we, mem_addr, mem_data);
    end
    drain("postreset");
  endtask

  initial begin
    test_reset();
    test_single_plot();
    test_clip();
    test_overflow_stall();
    test_full_push_pop();
    test_random();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/plot_sink.md
# plot_sink

Receiving end of the pixel-plot stream that the drawing blocks (square, block, ball, clear-screen drawers) emit as x/y/colour/plot. It clips each request to the visible screen, converts it to a linear framebuffer address, buffers it in a small FIFO, and drains it to the framebuffer write port under a ready/valid handshake. It also runs a full-screen clear sweep on request. It sits between the graphics mux and the VGA adapter's framebuffer memory.

## Interface
- WIDTH, 160, visible columns
- HEIGHT, 120, visible rows
- DEPTH, 8, FIFO entries (power of 2, ≥2)
- ADDR_W, 15, framebuffer address width (must hold WIDTH*HEIGHT-1)

- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- xin  in  12  pixel x from drawer
- yin  in  11  pixel y from drawer
- colourin  in  3  pixel colour
- plot  in  1  write request; sampled every cycle, one pixel per high cycle
- clear  in  1  single-cycle clear-screen request
- clear_colour  in  3  fill colour; sampled with clear
- mem_ready  in  1  framebuffer accepts write this cycle
- mem_addr  out  ADDR_W  framebuffer address
- mem_data  out  3  framebuffer colour
- mem_we  out  1  write valid
- busy  out  1  high while FIFO is non-empty or state ≠ IDLE
- full  out  1  FIFO count == DEPTH
- overflow  out  1  sticky: an in-bounds plot was dropped

## Operation
- Clip: a plot with xin ≥ WIDTH or yin ≥ HEIGHT is silently discarded; overflow is not set.
- Address: computed at push as yin*WIDTH + xin at full precision, then stored in ADDR_W bits. In-bounds values always fit.
- Push: an in-bounds plot is written as {addr, colourin} when count < DEPTH, or when a pop happens in the same cycle. Otherwise the plot is dropped and overflow is set to 1. Only reset clears overflow.
- Transfer: completes on a cycle where mem_we && mem_ready. While mem_we is high, mem_addr and mem_data hold stable until that cycle. mem_we is never withdrawn before it completes.
- States:
  - IDLE: mem_we=0. If the FIFO is non-empty, go to WRITE, presenting the head entry.
  - WRITE: present the head entry. On completion, pop; stay in WRITE if entries remain, else go to IDLE.
  - CLEAR: mem_addr sweeps 0 … WIDTH*HEIGHT-1 with mem_data = latched clear_colour. The address advances only on completion. After the last address completes, go to IDLE (or WRITE if the FIFO is non-empty).
- Clear acceptance:
  - In IDLE, or in WRITE with no transfer stalled: on the edge clear is sampled, flush the FIFO, latch clear_colour, zero the sweep address, and enter CLEAR.
  - In WRITE with mem_we high and mem_ready low: record clear as pending and hold the transfer. On its completion, flush and enter CLEAR. No mem_we gap is required.
- A plot sampled in the same cycle as an accepted clear is flushed with the rest of the FIFO.
- Plots arriving during CLEAR are pushed normally and drained after the sweep.
- A clear during CLEAR re-latches the colour and restarts the sweep at address 0 once the current address completes.

## Timing
- Reset (reset_n low at an edge): state IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_data=0, busy=0, full=0, overflow=0, clear pending=0. Takes effect immediately, including mid-sweep or mid-transfer.
- Latency: with FIFO empty and state IDLE, a plot sampled at edge k produces mem_we=1 with its address/data after edge k+1.
- Throughput: with mem_ready held high, one write completes per cycle. Sustained plot at 1/cycle never overflows.
- A clear sampled at edge k puts address 0 on mem_addr with mem_we=1 after edge k+1 (unless deferred by a stalled transfer).
- Sweep duration: WIDTH*HEIGHT completions (19200 with defaults).
- full and busy are registered, consistent with FIFO state after each edge.

## Test plan
- Single plot x=5, y=2, colour=3'b101, mem_ready=1 -> one write, mem_addr=325, mem_data=5, mem_we high for exactly one cycle, starting 2 edges after the plot.
- Plot x=160, y=0, then x=0, y=120 -> no mem_we, overflow stays 0.
- mem_ready=0, then 10 in-bounds plots (DEPTH=8) -> full=1 after 8, overflow=1. Release mem_ready -> exactly the first 8 written in order, address/data stable across stall.
- Full FIFO with mem_ready=1 and a simultaneous push and pop -> push accepted, overflow stays 0.
- clear with colour 3'b000 while 3 entries queued and the head stalled -> head completes, the other 2 are discarded, then 19200 writes 0..19199. A plot issued mid-sweep is written after address 19199.
- reset_n low mid-sweep at address 500 -> next cycle mem_we=0, busy=0, all outputs 0. A subsequent plot behaves as after a fresh reset.
